// File: rtl/timer_arbiter_if.sv
// timer_arbiter_if: requester-side bus of the shared countdown timer.
interface timer_arbiter_if #(
    parameter int NREQ = 4,
    parameter int CW   = 8
);
    logic            en;
    logic [NREQ-1:0] req;
    logic [NREQ*CW-1:0] load;
    logic [NREQ-1:0] grant;
    logic [NREQ-1:0] done;
    logic            busy;
    logic            tick;
    logic [CW-1:0]   q;

    modport master (output en, req, load, input grant, done, busy, tick, q);
    modport slave  (input en, req, load, output grant, done, busy, tick, q);
endinterface

// File: rtl/timer_arbiter.sv
// timer_arbiter: round-robin shared countdown timer clocked by a divide-by-DIV tick enable.
// Define TIMER_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) arbitration.
module timer_arbiter #(
    parameter int NREQ = 4,
    parameter int DIV  = 50,
    parameter int CW   = 8
) (
    input logic            clk,
    input logic            rst_n,
    timer_arbiter_if.slave bus
);
    localparam int OW = $clog2(NREQ);
    localparam int PW = $clog2(DIV);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_nxt;
    logic [OW-1:0] owner, winner, idx;
    logic          found;
    logic [PW-1:0] presc;
    logic [CW-1:0] q;
    logic          ptick, abort;

    // owner doubles as the round-robin pointer: it only changes at grant
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int i = 0; i < NREQ; i++) begin
`ifdef TIMER_ARB_FIXED_PRIO_EN
            idx = OW'(i);
`else
            idx = OW'((int'(owner) + 1 + i) % NREQ);
`endif
            if (!found && bus.req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign ptick = (state == RUN) && bus.en && (presc == PW'(DIV - 1));
    assign abort = !bus.req[owner];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // abort outranks completion, including a coincident final tick
    always_comb begin
        state_nxt = !bus.en        ? state :
                    state == IDLE  ? (found ? RUN : IDLE) :
                    state == RUN   ? (abort ? IDLE :
                                      (q == '0 || (ptick && q <= CW'(1))) ? DONE : RUN) :
                                     IDLE;
    end

    always_comb begin
        bus.grant = (state == RUN) ? NREQ'(1) << owner : '0;
        bus.done  = (state == DONE && bus.en) ? NREQ'(1) << owner : '0;
        bus.busy  = state == RUN;
        bus.tick  = ptick;
        bus.q     = q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner <= OW'(NREQ - 1);
            presc <= '0;
            q     <= '0;
        end else if (bus.en) begin
            if (state == IDLE && found) begin
                owner <= winner;
                q     <= bus.load[int'(winner)*CW +: CW];
                presc <= '0;
            end else if (state == RUN) begin
                presc <= ptick ? '0 : presc + 1'b1;
                if (abort || q == '0)
                    q <= '0;
                else if (ptick)
                    q <= q - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_timer_arbiter.sv
// tb_timer_arbiter: directed and randomized checks of timer_arbiter against a job-level timing model.
module tb_timer_arbiter;
    localparam int NREQ = 4;
    localparam int DIV  = 4;
    localparam int CW   = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   last;
    int   g, w;
    int   lv [NREQ];
    logic [NREQ-1:0] r;

    timer_arbiter_if #(.NREQ(NREQ), .CW(CW)) bus ();

    timer_arbiter #(.NREQ(NREQ), .DIV(DIV), .CW(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, observed cycle %0d required < %0d", cyc, 40000);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic set_load(input int i, input int v);
        bus.load[i*CW +: CW] = CW'(v);
    endtask

    // Round-robin winner from the last owner, or lowest index in fixed-priority builds.
    function automatic int predict(input logic [NREQ-1:0] m);
`ifdef TIMER_ARB_FIXED_PRIO_EN
        for (int i = 0; i < NREQ; i++)
            if (m[i]) return i;
`else
        for (int i = 1; i <= NREQ; i++)
            if (m[(last + i) % NREQ]) return (last + i) % NREQ;
`endif
        return -1;
    endfunction

    task automatic do_reset();
        rst_n    = 1'b0;
        bus.en   = 1'b1;
        bus.req  = '0;
        bus.load = '0;
        repeat (2) step();
        chk("rst_grant", bus.grant, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_tick", bus.tick, 0);
        chk("rst_q", bus.q, 0);
        rst_n = 1'b1;
        last  = NREQ - 1;
    endtask

    // Called in the grant cycle G; returns in the done cycle.
    task automatic run_job(input int wi, input int l, input bit scramble);
        int dn = (l == 0) ? 1 : l * DIV;
        logic [NREQ-1:0] oh = NREQ'(1) << wi;
        for (int n = 0; n <= dn; n++) begin
            if (n > 0) step();
            if (scramble && n == 1) begin
                bus.load = $urandom;
                bus.req  = (NREQ'($urandom) & ~oh) | oh;
            end
            if (n < dn) begin
                chk("run_grant", bus.grant, oh);
                chk("run_busy", bus.busy, 1);
                chk("run_done", bus.done, 0);
                chk("run_q", bus.q, l - n / DIV);
                chk("run_tick", bus.tick, (n % DIV) == DIV - 1);
            end else begin
                chk("end_done", bus.done, oh);
                chk("end_grant", bus.grant, 0);
                chk("end_busy", bus.busy, 0);
                chk("end_tick", bus.tick, 0);
                chk("end_q", bus.q, 0);
            end
        end
        last = wi;
    endtask

    initial begin
        rst_n    = 1'b0;
        bus.en   = 1'b0;
        bus.req  = '0;
        bus.load = '0;

        // single requester, load 3
        do_reset();
        set_load(0, 3);
        bus.req = 4'b0001;
        chk("single_pre_grant", bus.grant, 0);
        step();
        run_job(0, 3, 1'b0);
        step();
        chk("single_done_once", bus.done, 0);
        chk("single_idle_grant", bus.grant, 0);
        step();
        chk("single_regrant", bus.grant, 4'b0001);

        // round-robin with every load 1
        do_reset();
        bus.load = {NREQ{CW'(1)}};
        bus.req  = 4'b1111;
        step();
        for (int j = 0; j < 5; j++) begin
            run_job(predict(bus.req), 1, 1'b0);
            if (j < 4) begin
                step();
                chk("rr_gap", bus.grant, 0);
                step();
            end
        end

        // zero delay
        do_reset();
        set_load(2, 0);
        bus.req = 4'b0100;
        step();
        run_job(2, 0, 1'b0);

        // enable freeze for 10 cycles at G+5
        do_reset();
        set_load(0, 2);
        bus.req = 4'b0001;
        step();
        g = cyc;
        repeat (5) step();
        bus.en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            chk("freeze_tick", bus.tick, 0);
            chk("freeze_grant", bus.grant, 4'b0001);
            chk("freeze_q", bus.q, 1);
            chk("freeze_done", bus.done, 0);
            step();
        end
        bus.en = 1'b1;
        while (bus.done == 0 && cyc < g + 40) step();
        chk("freeze_done_cycle", cyc - g, 18);
        chk("freeze_done_val", bus.done, 4'b0001);

        // abort of owner 1 while requester 3 waits
        do_reset();
        set_load(1, 5);
        set_load(3, 1);
        bus.req = 4'b1010;
        step();
        chk("abort_first", bus.grant, 4'b0010);
        repeat (2) step();
        bus.req = 4'b1000;
        chk("abort_hold", bus.grant, 4'b0010);
        step();
        chk("abort_grant", bus.grant, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_q", bus.q, 0);
        chk("abort_busy", bus.busy, 0);
        last = 1;
        step();
        run_job(3, 1, 1'b0);

        // abort coincident with the final tick
        do_reset();
        set_load(0, 1);
        bus.req = 4'b0001;
        step();
        repeat (3) step();
        chk("abort_tick_tick", bus.tick, 1);
        bus.req = 4'b0000;
        step();
        chk("abort_tick_done", bus.done, 0);
        chk("abort_tick_grant", bus.grant, 0);
        step();
        chk("abort_tick_late", bus.done, 0);

        // reset asserted mid-run
        do_reset();
        set_load(0, 3);
        bus.req = 4'b0001;
        step();
        repeat (6) step();
        rst_n = 1'b0;
        #1;
        chk("midrst_grant", bus.grant, 0);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_q", bus.q, 0);
        chk("midrst_tick", bus.tick, 0);
        step();
        rst_n   = 1'b1;
        last    = NREQ - 1;
        bus.req = 4'b0011;
        step();
        chk("midrst_regrant", bus.grant, 4'b0001);
        run_job(0, 3, 1'b0);

        // max load with load and non-owner req disturbed after grant
        do_reset();
        set_load(3, 255);
        bus.req = 4'b1000;
        step();
        run_job(3, 255, 1'b1);

        // randomized jobs against the model
        do_reset();
        for (int it = 0; it < 25; it++) begin
            r = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++) begin
                lv[i] = $urandom_range(0, 5);
                set_load(i, lv[i]);
            end
            bus.req = r;
            w = predict(r);
            if (it > 0) begin
                step();
                chk("rand_gap", bus.grant, 0);
            end
            step();
            run_job(w, lv[w], 1'(($urandom) & 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
